// File: rtl/r3_divstep_stream.sv
// r3_divstep_stream: one R_3 divstep over a coefficient-serial (f,g) stream.
// Emits f' and g'=(F0*g-G0*f)/x one pair per accepted coefficient.
module r3_divstep_stream #(
  parameter int N  = 762,
  parameter int DW = 12,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] delta_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    f_in,
  input  logic [1:0]    g_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    f_out,
  output logic [1:0]    g_out,
  output logic          swap,
  output logic [DW-1:0] delta_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [DW-1:0] delta_r;
  logic          swap_r;
  logic [1:0]    lf, lg;
  logic [1:0]    fs_prev;
  logic          ov;
  logic [1:0]    fo, go;
  logic          fl;
  logic          done_r;

  logic          in_xfer, out_xfer;
  logic          is_idle, is_lead, is_run, is_flush;
  logic          swp_n;
  logic [DW-1:0] dsel, dnext;
  logic [1:0]    f0c, g0c;
  logic [1:0]    fs, gs, gnew;

  function automatic logic [1:0] canon(input logic [1:0] t);
    return t[0] ? t : 2'b00;
  endfunction

  function automatic logic [1:0] tmul(input logic [1:0] a,
                                      input logic [1:0] b);
    logic c0, c1;
    c0 = a[0] & b[0];
    c1 = (a[1] ^ b[1]) & c0;
    return {c1, c0};
  endfunction

  function automatic logic [1:0] tneg(input logic [1:0] a);
    return a[0] ? {~a[1], 1'b1} : 2'b00;
  endfunction

  // Sum of two canonical trits mod 3: +-2 wraps to -+1.
  function automatic logic [1:0] tadd(input logic [1:0] a,
                                      input logic [1:0] b);
    logic [1:0] r;
    if (!a[0])
      r = b;
    else if (!b[0])
      r = a;
    else if (a[1] == b[1])
      r = {~a[1], 1'b1};
    else
      r = 2'b00;
    return r;
  endfunction

  assign is_idle  = (state == S_IDLE);
  assign is_lead  = (state == S_LEAD);
  assign is_run   = (state == S_RUN);
  assign is_flush = (state == S_FLUSH);

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = ov & out_ready;

  assign f0c   = canon(f_in);
  assign g0c   = canon(g_in);
  assign swp_n = !delta_r[DW-1] && (|delta_r) && g_in[0];
  assign dsel  = swp_n ? (~delta_r + 1'b1) : delta_r;
  assign dnext = (dsel == DMAX) ? DMAX : dsel + 1'b1;

  assign fs   = swap_r ? g_in : f_in;
  assign gs   = swap_r ? f_in : g_in;
  assign gnew = tadd(tmul(lf, gs), tneg(tmul(lg, fs)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = S_LEAD;
      S_LEAD:  if (in_xfer) state_n = S_RUN;
      S_RUN:   if (in_xfer && cnt == LAST) state_n = S_FLUSH;
      S_FLUSH: if (fl && out_xfer) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    unique case (1'b1)
      is_lead:  in_ready = 1'b1;
      is_run:   in_ready = !ov || out_ready;
      is_idle:  in_ready = 1'b0;
      is_flush: in_ready = 1'b0;
      default:  in_ready = 1'b0;
    endcase
  end

  assign busy = !is_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      delta_r <= '0;
      swap_r  <= 1'b0;
      lf      <= 2'b00;
      lg      <= 2'b00;
      fs_prev <= 2'b00;
      ov      <= 1'b0;
      fo      <= 2'b00;
      go      <= 2'b00;
      fl      <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (out_xfer)
        ov <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            delta_r <= delta_in;
            cnt     <= '0;
            fl      <= 1'b0;
          end
        end
        S_LEAD: begin
          if (in_xfer) begin
            swap_r  <= swp_n;
            lf      <= swp_n ? g0c : f0c;
            lg      <= swp_n ? f0c : g0c;
            fs_prev <= swp_n ? g0c : f0c;
            delta_r <= dnext;
            cnt     <= CW'(1);
          end
        end
        S_RUN: begin
          if (in_xfer) begin
            ov      <= 1'b1;
            fo      <= fs_prev;
            go      <= gnew;
            fs_prev <= canon(fs);
            cnt     <= cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (!fl && (!ov || out_ready)) begin
            ov <= 1'b1;
            fo <= fs_prev;
            go <= 2'b00;
            fl <= 1'b1;
          end else if (fl && out_xfer) begin
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = ov;
  assign f_out     = fo;
  assign g_out     = go;
  assign swap      = swap_r;
  assign delta_out = delta_r;
  assign done      = done_r;

endmodule

// File: tb/tb_r3_divstep_stream.sv
// tb_r3_divstep_stream: directed divstep vectors, queue scoreboard
// with an independent output monitor.
module tb_r3_divstep_stream;

  localparam int N  = 4;
  localparam int DW = 12;
  localparam int CW = 10;

  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] M = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] delta_in;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    f_in, g_in;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    f_out, g_out;
  logic          swap;
  logic [DW-1:0] delta_out;
  logic          busy;
  logic          done;

  r3_divstep_stream #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .delta_in  (delta_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f_in      (f_in),
    .g_in      (g_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .g_out     (g_out),
    .swap      (swap),
    .delta_out (delta_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int pair_cnt = 0;
  logic [3:0] q[$];
  bit rdy_toggle = 1'b0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int ri = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_toggle) begin
      out_ready = pat[ri];
      ri = (ri + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer.
  bit         held_v = 1'b0;
  logic [3:0] held;
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid)
          chk("stall_data", {28'd0, f_out, g_out}, {28'd0, held});
      end
      if (out_valid && out_ready) begin
        pair_cnt++;
        held_v = 1'b0;
        if (q.size() == 0) begin
          chk("extra_pair", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("f_out", {30'd0, f_out}, {30'd0, e[3:2]});
          chk("g_out", {30'd0, g_out}, {30'd0, e[1:0]});
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {f_out, g_out};
      end else begin
        held_v = 1'b0;
      end
      if (done)
        done_cnt++;
    end
  end

  task automatic run_step(input logic [DW-1:0] d,
                          input logic [3:0][1:0] fv,
                          input logic [3:0][1:0] gv,
                          input logic [3:0][1:0] ef,
                          input logic [3:0][1:0] eg,
                          input bit gaps, input int nin,
                          input bit bstart, input bit ex_swap,
                          input logic [DW-1:0] ex_d);
    int d0, p0, c;
    bit xfer;
    d0 = done_cnt;
    p0 = pair_cnt;
    for (int i = 0; i < N; i++)
      q.push_back({ef[i], eg[i]});
    @(posedge clk); #1;
    start    = 1'b1;
    delta_in = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < nin; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      f_in = fv[i];
      g_in = gv[i];
      if (bstart && i == 2) begin
        start    = 1'b1;
        delta_in = 12'd5;
      end
      xfer = 1'b0;
      c = 0;
      while (!xfer && c < 50) begin
        @(negedge clk);
        xfer = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        c++;
      end
      if (!xfer)
        chk("in_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
    if (nin == N) begin
      c = 0;
      while (done_cnt == d0 && c < 100) begin
        @(posedge clk);
        c++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", done_cnt - d0, 32'd1);
      chk("pair_count", pair_cnt - p0, N);
      chk("queue_empty", q.size(), 32'd0);
      chk("swap", {31'd0, swap}, {31'd0, ex_swap});
      chk("delta_out", {20'd0, delta_out}, {20'd0, ex_d});
      chk("busy_idle", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ov"},    {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir"},    {31'd0, in_ready},  32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_done"},  {31'd0, done},      32'd0);
    chk({tag, "_swap"},  {31'd0, swap},      32'd0);
    chk({tag, "_delta"}, {20'd0, delta_out}, 32'd0);
    chk({tag, "_fg"},    {28'd0, f_out, g_out}, 32'd0);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; delta_in = '0;
    in_valid = 1'b0; f_in = Z; g_in = Z; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    in_valid = 1'b1; f_in = P; g_in = M;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
      chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // case 1
    run_step(12'd0, {Z,Z,P,P}, {Z,P,Z,P}, {Z,Z,P,P}, {Z,Z,P,M},
             1'b0, N, 1'b0, 1'b0, 12'd1);
    // case 2
    run_step(12'd1, {P,Z,Z,P}, {Z,Z,P,M}, {Z,Z,P,M}, {Z,M,Z,M},
             1'b0, N, 1'b0, 1'b1, 12'd0);
    // case 3
    run_step(12'd5, {Z,Z,Z,P}, {M,P,P,Z}, {Z,Z,Z,P}, {Z,M,P,P},
             1'b0, N, 1'b0, 1'b0, 12'd6);
    // case 4: stalls and input gaps
    rdy_toggle = 1'b1;
    run_step(12'd1, {P,Z,Z,P}, {Z,Z,P,M}, {Z,Z,P,M}, {Z,M,Z,M},
             1'b1, N, 1'b0, 1'b1, 12'd0);
    rdy_toggle = 1'b0;

    // case 5: abort after two inputs
    d0 = done_cnt;
    run_step(12'd0, {Z,Z,P,P}, {Z,P,Z,P}, {Z,Z,P,P}, {Z,Z,P,M},
             1'b0, 2, 1'b0, 1'b0, 12'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    run_step(12'd0, {Z,Z,P,P}, {Z,P,Z,P}, {Z,Z,P,P}, {Z,Z,P,M},
             1'b0, N, 1'b0, 1'b0, 12'd1);

    // case 6: saturation, non-canonical trit, start while busy
    run_step(12'd2047, {P,M,2'b10,P}, {Z,P,M,Z}, {P,M,Z,P},
             {Z,Z,P,M}, 1'b0, N, 1'b1, 1'b0, 12'd2047);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
